// File: rtl/servo_pwm_gen_if.sv
// Position command channel from the input filter stage.
// pos: 8-bit position; pos_valid: one-cycle strobe that captures pos.
interface servo_pwm_gen_if;
   logic [7:0] pos;
   logic       pos_valid;

   modport master (output pos, output pos_valid);
   modport slave  (input  pos, input  pos_valid);
endinterface

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: one active-high pulse per frame, width set
// by a double-buffered 8-bit position that only changes at frame starts.
// Ports: clk, reset (sync, active-high), enable (run request),
//   cmd (pos/pos_valid strobe), pwm (registered drive),
//   frame_start (one-cycle frame marker), busy (RUN or STOP).
module servo_pwm_gen #(
   parameter int TICK_DIV = 50,
   parameter int FRAME_US = 20000,
   parameter int MIN_US   = 1000,
   parameter int STEP_US  = 4,
   parameter int MAX_US   = 2000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   servo_pwm_gen_if.slave cmd,
   output logic           pwm,
   output logic           frame_start,
   output logic           busy
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam int PW = 8 + $clog2(STEP_US + 1);
   localparam int MW = $clog2(MAX_US + 1);
   localparam int SW = ((PW > MW) ? PW : MW) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   // Full-precision width, clamped; the clamp keeps it below FRAME_US
   // so it always fits the microsecond counter width.
   function automatic logic [CW-1:0] width_us(input logic [7:0] p);
      logic [PW-1:0] prod;
      logic [SW-1:0] sum;
      logic [CW-1:0] res;
      prod = PW'(p) * PW'(STEP_US);
      sum  = SW'(MIN_US) + SW'(prod);
      if (sum > SW'(MAX_US)) begin
         res = CW'(MAX_US);
      end else begin
         res = CW'(sum);
      end
      return res;
   endfunction

   state_t        state_q, state_d;
   logic [TW-1:0] presc_q, presc_d;
   logic [CW-1:0] us_cnt_q, us_cnt_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic [CW-1:0] active_q, active_d;
   logic          pwm_q, pwm_d;
   logic          fs_q, fs_d;

   logic          tick;
   logic          wrap;
   logic [TW-1:0] presc_nx;
   logic [CW-1:0] us_nx;

   always_comb begin
      tick     = (presc_q == TW'(TICK_DIV - 1));
      wrap     = tick && (us_cnt_q == CW'(FRAME_US - 1));
      presc_nx = tick ? '0 : presc_q + TW'(1);
      if (!tick) begin
         us_nx = us_cnt_q;
      end else if (wrap) begin
         us_nx = '0;
      end else begin
         us_nx = us_cnt_q + CW'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      us_cnt_d = us_cnt_q;
      active_d = active_q;
      pwm_d    = 1'b0;
      fs_d     = 1'b0;
      shadow_d = cmd.pos_valid ? width_us(cmd.pos) : shadow_q;

      unique case (state_q)
         IDLE: begin
            presc_d  = '0;
            us_cnt_d = '0;
            if (enable) begin
               state_d  = RUN;
               active_d = shadow_q;
               fs_d     = 1'b1;
               pwm_d    = (shadow_q != '0);
            end
         end
         RUN: begin
            presc_d  = presc_nx;
            us_cnt_d = us_nx;
            if (!enable) begin
               // A stop on the wrap edge suppresses the new frame.
               state_d = STOP;
               pwm_d   = !wrap && (us_nx < active_q);
            end else if (wrap) begin
               active_d = shadow_q;
               fs_d     = 1'b1;
               pwm_d    = (shadow_q != '0);
            end else begin
               pwm_d = (us_nx < active_q);
            end
         end
         STOP: begin
            presc_d  = presc_nx;
            us_cnt_d = us_nx;
            if (pwm_q && (us_nx < active_q)) begin
               pwm_d = 1'b1;
            end else begin
               state_d  = IDLE;
               presc_d  = '0;
               us_cnt_d = '0;
            end
         end
         default: begin
            state_d  = IDLE;
            presc_d  = '0;
            us_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         us_cnt_q <= '0;
         shadow_q <= width_us(8'd125);
         active_q <= width_us(8'd125);
         pwm_q    <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         us_cnt_q <= us_cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
         fs_q     <= fs_d;
      end
   end

   assign pwm         = pwm_q;
   assign frame_start = fs_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Generates the standard hobby-servo drive waveform: one active-high pulse per fixed-length frame, pulse width set by an 8-bit position command. Sits directly downstream of the servo input filter stage, which delivers cleaned position commands via a one-cycle strobe. The block double-buffers commands so a new position only takes effect at a frame boundary, and it never emits a truncated pulse.

## Interface

- TICK_DIV, 50: clocks per microsecond tick (50 MHz clock).
- FRAME_US, 20000: frame period in µs.
- MIN_US, 1000: pulse width for position 0, in µs.
- STEP_US, 4: µs added per position LSB.
- MAX_US, 2000: pulse width clamp, in µs. Legal configurations require MIN_US ≤ MAX_US < FRAME_US and TICK_DIV ≥ 1.

- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request, level-sensitive.
- pos  in  8  position command.
- pos_valid  in  1  one-cycle strobe; captures pos.
- pwm  out  1  servo drive, registered.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame, registered.
- busy  out  1  high in RUN or STOP states.

## Operation

- **Width rule:** width_us = min(MIN_US + pos·STEP_US, MAX_US).
  - Compute it at full precision: the product is 8+clog2(STEP_US+1) bits, and the sum gets one extra bit before the clamp.
- **Shadow register:**
  - On any cycle with pos_valid=1, shadow ← width_us(pos), regardless of state or enable.
  - Reset value of shadow is width_us(125), which is 1500 µs with the defaults.
- **Active register:** active ← shadow only at a frame start. The width never changes mid-frame.
- **Counters:**
  - presc counts 0..TICK_DIV-1; tick = (presc == TICK_DIV-1).
  - us_cnt counts 0..FRAME_US-1 and advances on tick.
  - us_cnt wraps from FRAME_US-1 to 0 and starts a new frame.
- **FSM states:** IDLE, RUN, STOP.
  - IDLE: pwm=0, counters held at 0. When enable=1: go to RUN, load active ← shadow, set pwm←1 and frame_start←1.
  - RUN: pwm = (us_cnt < active), registered. When the frame wraps: reload active, pulse frame_start, set pwm←1. When enable=0 is sampled: go to STOP.
  - STOP: if pwm=1, hold the current pulse until us_cnt reaches active, then go to IDLE with pwm←0. If pwm=0 on entry, go to IDLE on the next edge. enable is ignored while in STOP.
- **Simultaneous events:**
  - pos_valid on the same edge as a frame start: active takes the old shadow; the new value applies from the following frame.
  - enable falling on a frame-wrap edge: the new frame does not start; go to STOP with pwm=0, which reaches IDLE on the next edge.
- **Reset (any state, mid-pulse included):** state=IDLE, pwm=0, frame_start=0, busy=0, presc=0, us_cnt=0, shadow=width_us(125), active=shadow.

## Timing

- **Start latency:** enable sampled high in IDLE at edge N → pwm=1, frame_start=1, busy=1 visible after edge N.
- **Pulse length:** pwm stays high for exactly active·TICK_DIV clocks.
- **Frame length:** exactly FRAME_US·TICK_DIV clocks from one frame_start to the next.
- **frame_start:** high for exactly one clock per frame.
- **Command latency:** a pos_valid at any point in frame k takes effect at the start of frame k+1. Only the last strobe before the boundary counts.
- **Stop latency:** the pulse is completed, then busy falls on the same edge that pwm falls. If enable drops during the low phase, busy falls one cycle later.

## Test plan

Bench parameters for all scenarios: TICK_DIV=2, FRAME_US=100, MIN_US=10, STEP_US=1, MAX_US=60.

- **Reset and idle:** apply reset for 3 cycles, keep enable=0 for 500 cycles → pwm=0, busy=0, frame_start=0 throughout.
- **Default width:** after reset, enable=1 → first pulse is 120 clocks high (60 µs, clamped from 135) and 80 clocks low; frame_start repeats every 200 clocks.
- **Frame-boundary update:** pos=20 with pos_valid mid-frame → current frame keeps its old width; next frame's pulse is 60 clocks. A pos_valid coincident with frame_start also applies one frame later.
- **Clamp and minimum:**
  - pos=255 → 120 clocks (clamped).
  - pos=0 → 20 clocks.
- **Stop mid-pulse:** with pos=20, drop enable 10 clocks into the pulse → pwm stays high for the full 60 clocks, then pwm=0 and busy=0 on the same edge, and no further frame_start. Re-enable → new frame starts one cycle after enable is sampled.
- **Reset mid-pulse:** assert reset while pwm=1 → pwm=0 and busy=0 the cycle after reset is sampled; shadow is restored so the next enable gives 120 clocks.
